// File: rtl/rcas_pkg.sv
// rtl/rcas_pkg.sv - shared constants for the sequential ripple-carry add/sub
//
// Purpose: FSM state encoding and operation codes used by rcas_seq.
// Ports:   none (package).
package rcas_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Operation select carried on the con input
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/rcas_slice.sv
// rtl/rcas_slice.sv - combinational DIGIT-bit ripple-carry adder slice
//
// Purpose: adds one DIGIT-bit slice of the operands plus a carry-in.
// Ports:
//   a, b      in  DIGIT  slice operands (b already conditionally inverted)
//   cin       in  1      carry into bit 0 of the slice
//   s         out DIGIT  slice sum
//   cout      out 1      carry out of the slice MSB
//   c_msb_in  out 1      carry into the slice MSB (only with RCAS_OVF_EN)
// Configuration: RCAS_OVF_EN adds the c_msb_in tap for overflow detection.
module rcas_slice #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
`ifdef RCAS_OVF_EN
   output logic             c_msb_in,
`endif
   output logic             cout
);

   always_comb begin : ripple
      logic c;
      c = cin;
      s = '0;
`ifdef RCAS_OVF_EN
      c_msb_in = cin;
`endif
      for (int i = 0; i < DIGIT; i++) begin
`ifdef RCAS_OVF_EN
         if (i == DIGIT - 1) begin
            c_msb_in = c;
         end
`endif
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/rcas_seq.sv
// rtl/rcas_seq.sv - multi-cycle ripple-carry adder/subtractor, DIGIT bits per clock
//
// Purpose: computes A+B or A-B over N = WIDTH/DIGIT clock cycles, one slice per
//          cycle, with the carry registered between slices. start/done handshake.
// Parameters: WIDTH >= 1, DIGIT must divide WIDTH.
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      asynchronous active-high reset
//   start  in  1      request, honoured only in IDLE or DONE
//   A, B   in  WIDTH  operands, captured on the accepting edge
//   con    in  1      0 = A+B, 1 = A-B; captured on the accepting edge
//   busy   out 1      high while slices are being processed
//   done   out 1      one-cycle pulse, S/Cout (and V) valid
//   S      out WIDTH  result modulo 2^WIDTH, holds until the next accept
//   Cout   out 1      carry out of MSB (for subtraction: 1 = no borrow)
//   V      out 1      signed overflow (only with RCAS_OVF_EN)
// Configuration: define RCAS_OVF_EN to add the V output.
module rcas_seq
   import rcas_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             con,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
`ifdef RCAS_OVF_EN
   output logic             V,
`endif
   output logic             Cout
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [1:0]       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] bx_r;
   logic             carry;

   logic [DIGIT-1:0] a_sl;
   logic [DIGIT-1:0] b_sl;
   logic [DIGIT-1:0] s_sl;
   logic             cout_sl;
`ifdef RCAS_OVF_EN
   logic             cmsb_sl;
`endif

   // A single slice adder is shared across cycles; count picks the slice.
   assign a_sl = a_r[int'(count) * DIGIT +: DIGIT];
   assign b_sl = bx_r[int'(count) * DIGIT +: DIGIT];

   rcas_slice #(
      .DIGIT (DIGIT)
   ) u_slice (
      .a        (a_sl),
      .b        (b_sl),
      .cin      (carry),
      .s        (s_sl),
`ifdef RCAS_OVF_EN
      .c_msb_in (cmsb_sl),
`endif
      .cout     (cout_sl)
   );

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
         a_r   <= '0;
         bx_r  <= '0;
         carry <= 1'b0;
         S     <= '0;
         Cout  <= 1'b0;
`ifdef RCAS_OVF_EN
         V     <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_r   <= A;
                  // Subtraction is A + ~B + 1: invert B here, the +1 enters as carry-in.
                  bx_r  <= B ^ {WIDTH{con}};
                  carry <= (con == OP_SUB);
                  count <= '0;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               S[int'(count) * DIGIT +: DIGIT] <= s_sl;
               carry <= cout_sl;
               if (count == LAST) begin
                  Cout  <= cout_sl;
`ifdef RCAS_OVF_EN
                  // Last slice holds the MSB, so its top-bit carries give overflow.
                  V     <= cmsb_sl ^ cout_sl;
`endif
                  state <= ST_DONE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
